// File: rtl/pathfinding_pkg.sv
// Shared types and constants for the pathfinding result path.
//
// Contents:
//   node_info_t      - 17 x 16-bit node record, x in the most significant field
//   WORDS_PER_NODE   - 16-bit words per record (17)
//   NODE_W           - record width in bits (272)
//   STATUS_*_BIT     - bit positions inside the status word
//   wr_state_e       - state encoding of the path_result_writer FSM
//
// Build option: PATH_WR_CHECKSUM_EN adds the StWriteCsum state.
package pathfinding_pkg;

  localparam int unsigned WORDS_PER_NODE  = 17;
  localparam int unsigned NODE_W          = 272;
  localparam int unsigned WORD_IDX_W      = $clog2(WORDS_PER_NODE);
  localparam int unsigned STATUS_DONE_BIT = 0;
  localparam int unsigned STATUS_OVF_BIT  = 1;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] g_cost;
    logic [15:0] h_cost;
    logic [15:0] f_cost;
    logic [15:0] parent_x;
    logic [15:0] parent_y;
    logic [15:0] flags;
    logic [15:0] heading;
    logic [15:0] child_count;
    logic [15:0] distance_child_zero;
    logic [15:0] distance_child_one;
    logic [15:0] distance_child_two;
    logic [15:0] distance_child_three;
    logic [15:0] distance_child_four;
    logic [15:0] distance_child_five;
    logic [15:0] distance_child_six;
  } node_info_t;

  typedef enum logic [2:0] {
    StIdle,
    StWriteNode,
    StSkip,
    StWriteCount,
    StWriteStatus,
`ifdef PATH_WR_CHECKSUM_EN
    StWriteCsum,
`endif
    StDone
  } wr_state_e;

endpackage

// File: rtl/path_result_writer_if.sv
// Bundle of the node record stream and the shared-memory write port.
//
// Signals:
//   node_data/node_valid/node_last/node_ready - record handshake from the core
//   address/writedata/write/waitrequest       - word write port into shared memory
//
// Modports:
//   master - the writer (consumes records, drives the memory port)
//   slave  - the environment (produces records, owns the memory)
interface path_result_writer_if #(
  parameter int unsigned ADDR_W = 10
);
  import pathfinding_pkg::*;

  node_info_t        node_data;
  logic              node_valid;
  logic              node_last;
  logic              node_ready;
  logic [ADDR_W-1:0] address;
  logic [15:0]       writedata;
  logic              write;
  logic              waitrequest;

  modport master (
    input  node_data,
    input  node_valid,
    input  node_last,
    output node_ready,
    output address,
    output writedata,
    output write,
    input  waitrequest
  );

  modport slave (
    output node_data,
    output node_valid,
    output node_last,
    input  node_ready,
    input  address,
    input  writedata,
    input  write,
    output waitrequest
  );

endinterface

// File: rtl/path_result_writer_node_serializer.sv
// Splits one latched node_info record into 16-bit words, most significant first.
//
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   load        - capture load_data and restart at word 0
//   load_data   - 272-bit record
//   advance     - step to the next word (ignored once the last word is shown)
//   word        - current 16-bit word
//   index       - current word index 0..16
//   last_word   - current word is word 16
module node_serializer
  import pathfinding_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [NODE_W-1:0]     load_data,
  input  logic                  advance,
  output logic [15:0]           word,
  output logic [WORD_IDX_W-1:0] index,
  output logic                  last_word
);

  logic [NODE_W-1:0]     shift_q;
  logic [WORD_IDX_W-1:0] index_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      index_q <= '0;
    end else if (load) begin
      shift_q <= load_data;
      index_q <= '0;
    end else if (advance && !last_word) begin
      shift_q <= {shift_q[NODE_W-17:0], 16'h0000};
      index_q <= index_q + WORD_IDX_W'(1);
    end
  end

  assign word      = shift_q[NODE_W-1 -: 16];
  assign index     = index_q;
  assign last_word = (index_q == WORD_IDX_W'(WORDS_PER_NODE - 1));

endmodule

// File: rtl/path_result_writer.sv
// Writes a path of node_info records into HPS-shared memory, then a node-count
// word and a status word, then pulses done_pulse.
//
// Memory layout (word addresses):
//   BASE_ADDR      node count (saturates at MAX_NODES)
//   BASE_ADDR + 1  status {14'b0, overflow, 1'b1}
//   BASE_ADDR + 2  records, 17 words each, record i at BASE_ADDR + 2 + i*17
//
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   bus         - record stream in, memory write port out (master modport)
//   busy        - a path is being written
//   overflow    - more than MAX_NODES records offered in the current path
//   done_pulse  - one cycle after the last path word is committed
//
// Build option: PATH_WR_CHECKSUM_EN appends a 16-bit XOR of all stored record
// words at BASE_ADDR + 2 + MAX_NODES*17 after the status word.
module path_result_writer
  import pathfinding_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_NODES = 32,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  path_result_writer_if.master bus,
  output logic                 busy,
  output logic                 overflow,
  output logic                 done_pulse
);

  localparam int unsigned IDX_W = $clog2(MAX_NODES + 1);

  localparam logic [ADDR_W-1:0] COUNT_ADDR  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(BASE_ADDR + 1);
  localparam logic [ADDR_W-1:0] REC_ADDR    = ADDR_W'(BASE_ADDR + 2);
`ifdef PATH_WR_CHECKSUM_EN
  localparam logic [ADDR_W-1:0] CSUM_ADDR   =
      ADDR_W'(BASE_ADDR + 2 + MAX_NODES * WORDS_PER_NODE);
`endif

  wr_state_e         state_q;
  logic [IDX_W-1:0]  node_index_q;
  logic              last_q;
  logic              node_ready_q;
  logic              write_q;
  logic              busy_q;
  logic              overflow_q;
  logic              done_q;
`ifdef PATH_WR_CHECKSUM_EN
  logic [15:0]       csum_q;
`endif

  logic                  accept;
  logic                  ser_advance;
  logic [15:0]           ser_word;
  logic [WORD_IDX_W-1:0] ser_index;
  logic                  ser_last;
  logic [ADDR_W-1:0]     rec_addr;
  logic [15:0]           status_word;

  assign accept      = bus.node_valid && node_ready_q;
  assign ser_advance = (state_q == StWriteNode) && !bus.waitrequest;

  node_serializer u_serializer (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .load_data (bus.node_data),
    .advance   (ser_advance),
    .word      (ser_word),
    .index     (ser_index),
    .last_word (ser_last)
  );

  // node_index_q only changes after the last word of a record, so the record
  // base can be derived from it directly.
  assign rec_addr = REC_ADDR + ADDR_W'(node_index_q) * ADDR_W'(WORDS_PER_NODE)
                  + ADDR_W'(ser_index);

  always_comb begin
    status_word                  = '0;
    status_word[STATUS_DONE_BIT] = 1'b1;
    status_word[STATUS_OVF_BIT]  = overflow_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      node_index_q <= '0;
      last_q       <= 1'b0;
      node_ready_q <= 1'b0;
      write_q      <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
`ifdef PATH_WR_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          node_ready_q <= 1'b1;
          if (accept) begin
            node_ready_q <= 1'b0;
            last_q       <= bus.node_last;
            busy_q       <= 1'b1;
            // Not busy means this record opens a new path.
            if (!busy_q) begin
              overflow_q <= 1'b0;
`ifdef PATH_WR_CHECKSUM_EN
              csum_q     <= '0;
`endif
            end
            if (node_index_q >= IDX_W'(MAX_NODES)) begin
              state_q <= StSkip;
            end else begin
              state_q <= StWriteNode;
              write_q <= 1'b1;
            end
          end
        end

        StWriteNode: begin
          if (!bus.waitrequest) begin
`ifdef PATH_WR_CHECKSUM_EN
            csum_q <= csum_q ^ ser_word;
`endif
            if (ser_last) begin
              node_index_q <= node_index_q + IDX_W'(1);
              if (last_q) begin
                state_q <= StWriteCount;
              end else begin
                state_q      <= StIdle;
                write_q      <= 1'b0;
                node_ready_q <= 1'b1;
              end
            end
          end
        end

        StSkip: begin
          overflow_q <= 1'b1;
          if (last_q) begin
            state_q <= StWriteCount;
            write_q <= 1'b1;
          end else begin
            state_q      <= StIdle;
            node_ready_q <= 1'b1;
          end
        end

        StWriteCount: begin
          if (!bus.waitrequest) begin
            state_q <= StWriteStatus;
          end
        end

        StWriteStatus: begin
          if (!bus.waitrequest) begin
`ifdef PATH_WR_CHECKSUM_EN
            state_q <= StWriteCsum;
`else
            state_q      <= StDone;
            write_q      <= 1'b0;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            node_index_q <= '0;
`endif
          end
        end

`ifdef PATH_WR_CHECKSUM_EN
        StWriteCsum: begin
          if (!bus.waitrequest) begin
            state_q      <= StDone;
            write_q      <= 1'b0;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
            node_index_q <= '0;
          end
        end
`endif

        StDone: begin
          state_q      <= StIdle;
          node_ready_q <= 1'b1;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Address and data are pure selects of registered state, so they hold
  // steady for as long as waitrequest stalls the FSM.
  always_comb begin
    bus.address   = '0;
    bus.writedata = '0;
    case (state_q)
      StWriteNode: begin
        bus.address   = rec_addr;
        bus.writedata = ser_word;
      end
      StWriteCount: begin
        bus.address   = COUNT_ADDR;
        bus.writedata = 16'(node_index_q);
      end
      StWriteStatus: begin
        bus.address   = STATUS_ADDR;
        bus.writedata = status_word;
      end
`ifdef PATH_WR_CHECKSUM_EN
      StWriteCsum: begin
        bus.address   = CSUM_ADDR;
        bus.writedata = csum_q;
      end
`endif
      default: begin
        bus.address   = '0;
        bus.writedata = '0;
      end
    endcase
  end

  assign bus.node_ready = node_ready_q;
  assign bus.write      = write_q;
  assign busy           = busy_q;
  assign overflow       = overflow_q;
  assign done_pulse     = done_q;

endmodule

// File: tb/tb_path_result_writer.sv
// Self-checking bench for path_result_writer: directed paths with random record
// contents, a memory-side monitor logging committed writes, and a reference
// model that lays out the expected memory writes from the path's records.
module tb_path_result_writer;
  import pathfinding_pkg::*;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned MAX_NODES = 32;
  localparam int unsigned BASE_ADDR = 0;
  localparam int unsigned CSUM_ADDR = BASE_ADDR + 2 + MAX_NODES * WORDS_PER_NODE;
`ifdef PATH_WR_CHECKSUM_EN
  localparam int unsigned CSUM_EXTRA = 1;
`else
  localparam int unsigned CSUM_EXTRA = 0;
`endif

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic busy, overflow, done_pulse;

  logic [NODE_W-1:0] nd  = '0;
  logic              nv  = 1'b0;
  logic              nl  = 1'b0;
  logic              wrq = 1'b0;

  path_result_writer_if #(.ADDR_W(ADDR_W)) bus ();

  assign bus.node_data   = nd;
  assign bus.node_valid  = nv;
  assign bus.node_last   = nl;
  assign bus.waitrequest = wrq;

  path_result_writer #(
    .ADDR_W    (ADDR_W),
    .MAX_NODES (MAX_NODES),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .busy       (busy),
    .overflow   (overflow),
    .done_pulse (done_pulse)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory-side monitor, sampled mid-cycle: a write seen with waitrequest low
  // is the one committed at the next rising edge.
  wr_t         log_q[$];
  logic [15:0] mem [0:1023];
  int unsigned addr_cycles [0:1023];
  int unsigned done_count = 0;
  int unsigned done_cyc   = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (bus.write) begin
        addr_cycles[bus.address] = addr_cycles[bus.address] + 1;
        if (!bus.waitrequest) begin
          log_q.push_back('{addr: 16'(bus.address), data: bus.writedata});
          mem[bus.address] = bus.writedata;
        end
      end
      if (done_pulse) begin
        done_count = done_count + 1;
        done_cyc   = cyc;
      end
    end
  end

  // waitrequest driver: 0 = low, 1 = random, 2 = one 3-cycle stall on address 7
  int wr_mode    = 0;
  int stall_left = 0;
  bit stall_used = 1'b0;

  always @(posedge clk) begin
    #1;
    case (wr_mode)
      1: wrq = ($urandom_range(0, 3) == 0);
      2: begin
        if (stall_left > 0) begin
          wrq = 1'b1;
          stall_left--;
        end else if (!stall_used && bus.write && bus.address == ADDR_W'(BASE_ADDR + 2 + 5)) begin
          wrq        = 1'b1;
          stall_left = 2;
          stall_used = 1'b1;
        end else begin
          wrq = 1'b0;
        end
      end
      default: wrq = 1'b0;
    endcase
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected sequence of committed memory writes for a path.
  logic [NODE_W-1:0] path_recs[$];
  wr_t               exp_q[$];
  bit                exp_ovf;

  function automatic void build_expected();
    int unsigned       stored = 0;
    logic [15:0]       cs     = '0;
    logic [NODE_W-1:0] r;
    logic [15:0]       w;
    exp_q.delete();
    exp_ovf = 1'b0;
    foreach (path_recs[i]) begin
      r = path_recs[i];
      if (stored < MAX_NODES) begin
        for (int k = 0; k < WORDS_PER_NODE; k++) begin
          w = r[NODE_W-1-16*k -: 16];
          exp_q.push_back('{addr: 16'(BASE_ADDR + 2 + stored * WORDS_PER_NODE + k), data: w});
          cs = cs ^ w;
        end
        stored++;
      end else begin
        exp_ovf = 1'b1;
      end
    end
    exp_q.push_back('{addr: 16'(BASE_ADDR), data: 16'(stored)});
    exp_q.push_back('{addr: 16'(BASE_ADDR + 1), data: {14'b0, exp_ovf, 1'b1}});
`ifdef PATH_WR_CHECKSUM_EN
    exp_q.push_back('{addr: 16'(CSUM_ADDR), data: cs});
`endif
  endfunction

  function automatic logic [NODE_W-1:0] rand_rec();
    logic [NODE_W-1:0] r;
    for (int k = 0; k < WORDS_PER_NODE; k++) r[NODE_W-1-16*k -: 16] = 16'($urandom_range(0, 65535));
    return r;
  endfunction

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send_node(input logic [NODE_W-1:0] d, input bit l, output int unsigned acc);
    int t = 0;
    nd = d;
    nl = l;
    nv = 1'b1;
    while (!bus.node_ready && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.node_ready) check("accept timeout", 32'(bus.node_ready), 32'd1);
    @(posedge clk); #1;
    acc = cyc;
    nv  = 1'b0;
  endtask

  task automatic wait_ready(output int g);
    g = 0;
    while (!bus.node_ready && g < 1000) begin
      @(posedge clk); #1;
      g++;
    end
  endtask

  task automatic run_path(input bit chk_timing, input string tag);
    int          start = log_q.size();
    int unsigned dc0   = done_count;
    int unsigned acc   = 0;
    int          g;
    int          t     = 0;
    int          n;
    bit          bad   = 1'b0;
    build_expected();
    foreach (path_recs[i]) begin
      send_node(path_recs[i], (i == path_recs.size() - 1), acc);
      if (chk_timing && i < MAX_NODES) begin
        check({tag, " first write"}, 32'(bus.write), 32'd1);
        check({tag, " first addr"}, 32'(bus.address), 32'(BASE_ADDR + 2 + i * WORDS_PER_NODE));
        if (i != path_recs.size() - 1) begin
          wait_ready(g);
          check({tag, " ready gap"}, 32'(g), 32'd17);
        end
      end
    end
    while (done_count == dc0 && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, " done pulses"}, 32'(done_count - dc0), 32'd1);
    if (chk_timing) check({tag, " done latency"}, done_cyc, acc + 19 + CSUM_EXTRA);
    check({tag, " write count"}, 32'(log_q.size() - start), 32'(exp_q.size()));
    n = (log_q.size() - start < exp_q.size()) ? log_q.size() - start : exp_q.size();
    for (int i = 0; i < n && !bad; i++) begin
      check({tag, " write seq"}, log_q[start+i], exp_q[i]);
      bad = (log_q[start+i] !== exp_q[i]);
    end
    check({tag, " busy end"}, 32'(busy), 32'd0);
    check({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
    check({tag, " ready end"}, 32'(bus.node_ready), 32'd1);
  endtask

  initial begin
    logic [NODE_W-1:0] r;
    int unsigned       acc;
    int                g;
    int                t;
    int                start;
    int unsigned       a7_before;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst write", 32'(bus.write), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    check("rst done", 32'(done_pulse), 32'd0);
    check("rst ready", 32'(bus.node_ready), 32'd0);
    check("rst address", 32'(bus.address), 32'd0);
    check("rst writedata", 32'(bus.writedata), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("ready after reset", 32'(bus.node_ready), 32'd1);

    // Single node with fixed fields
    for (int k = 0; k < WORDS_PER_NODE; k++) r[NODE_W-1-16*k -: 16] = 16'h0011 + 16'(k * 14);
    r[15:0] = 16'h00FF;
    path_recs.delete();
    path_recs.push_back(r);
    run_path(1'b1, "single");
    check("single count", 32'(mem[BASE_ADDR]), 32'd1);
    check("single status", 32'(mem[BASE_ADDR+1]), 32'h0001);

    // Three random nodes
    path_recs.delete();
    repeat (3) path_recs.push_back(rand_rec());
    run_path(1'b1, "three");
    check("three count", 32'(mem[BASE_ADDR]), 32'd3);

    // 3-cycle stall on word 5 of node 0
    a7_before = addr_cycles[BASE_ADDR+7];
    wr_mode   = 2;
    path_recs.delete();
    repeat (2) path_recs.push_back(rand_rec());
    run_path(1'b0, "stall");
    check("stall hold cycles", addr_cycles[BASE_ADDR+7] - a7_before, 32'd4);
    wr_mode = 0;

    // 34 nodes against 32 slots, random waitrequest
    wr_mode = 1;
    path_recs.delete();
    repeat (34) path_recs.push_back(rand_rec());
    run_path(1'b0, "overflow");
    wr_mode = 0;
    check("ovf count", 32'(mem[BASE_ADDR]), 32'd32);
    check("ovf status", 32'(mem[BASE_ADDR+1]), 32'h0003);
    @(posedge clk); #1;

    // Next path after an overflow starts clean
    path_recs.delete();
    path_recs.push_back(rand_rec());
    run_path(1'b1, "after ovf");
    check("after ovf status", 32'(mem[BASE_ADDR+1]), 32'h0001);

    // Reset during word 9 of node 1
    start = log_q.size();
    send_node(rand_rec(), 1'b0, acc);
    wait_ready(g);
    send_node(rand_rec(), 1'b0, acc);
    t = 0;
    while (!(bus.write && bus.address == ADDR_W'(BASE_ADDR + 2 + 17 + 9)) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("reach word 9", 32'(bus.address), 32'(BASE_ADDR + 2 + 17 + 9));
    reset = 1'b0;
    #1;
    check("async write", 32'(bus.write), 32'd0);
    check("async busy", 32'(busy), 32'd0);
    check("async ready", 32'(bus.node_ready), 32'd0);
    check("partial writes", 32'(log_q.size() - start), 32'd26);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("ready after mid reset", 32'(bus.node_ready), 32'd1);
    path_recs.delete();
    path_recs.push_back(rand_rec());
    run_path(1'b1, "post reset");
    check("post reset count", 32'(mem[BASE_ADDR]), 32'd1);

    // Record of words 1..17
    for (int k = 0; k < WORDS_PER_NODE; k++) r[NODE_W-1-16*k -: 16] = 16'(k + 1);
    path_recs.delete();
    path_recs.push_back(r);
    run_path(1'b1, "ramp");
`ifdef PATH_WR_CHECKSUM_EN
    check("checksum word", 32'(mem[CSUM_ADDR]), 32'h0001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
